// File: rtl/mac_tx_frame_buffer_if.sv
// Avalon-ST beat bus used on both sides of the TX frame buffer.
interface mac_tx_frame_buffer_if #(
   parameter int unsigned DATA_WIDTH  = 256,
   parameter int unsigned EMPTY_WIDTH = 5
);
   logic [DATA_WIDTH-1:0]  data;
   logic                   valid;
   logic                   sop;
   logic                   eop;
   logic [EMPTY_WIDTH-1:0] empty;
   logic                   error;
   logic                   ready;

   modport master (output data, valid, sop, eop, empty, error, input ready);
   modport slave  (input data, valid, sop, eop, empty, error, output ready);
endinterface

// File: rtl/mac_tx_frame_buffer.sv
// Store-and-forward TX frame buffer between udp_ip and the MAC: only complete, error-free frames
// are released; partial, errored or overflowing frames are dropped and counted.
module mac_tx_frame_buffer #(
   parameter int unsigned DATA_WIDTH      = 256,
   parameter int unsigned EMPTY_WIDTH     = 5,
   parameter int unsigned LOG_DEPTH       = 6,
   parameter int unsigned MAX_FRAME_BEATS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   mac_tx_frame_buffer_if.slave  in_bus,
   mac_tx_frame_buffer_if.master out_bus,
   output logic [31:0]           pckt_drop_cnt_out,
   output logic                  error
);
   localparam int unsigned Depth = 2 ** LOG_DEPTH;
   localparam int unsigned PtrW  = LOG_DEPTH + 1;
   localparam int unsigned WordW = DATA_WIDTH + EMPTY_WIDTH + 2;
   localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
   localparam logic [PtrW-1:0] PtrDepth = PtrW'(Depth);
   localparam logic [PtrW-1:0] PtrMax   = PtrW'(MAX_FRAME_BEATS);

   typedef enum logic [1:0] {StIdle, StRecv, StDrop} wr_state_e;

   wr_state_e            state_q, state_d;
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]      wr_commit_q, wr_commit_d;
   logic [PtrW-1:0]      rd_ptr_q;
   logic                 frame_err_q, frame_err_d;
   logic                 error_q, error_d;
   logic [31:0]          drop_cnt_q;
   logic                 drop_a, drop_b;
   logic                 wr_en, start_frame;
   logic [LOG_DEPTH-1:0] wr_addr;
   logic                 full_app, full_start;
   logic [PtrW-1:0]      free_beats;
   logic                 in_ready_q;

   logic [WordW-1:0]     mem [Depth];
   logic [WordW-1:0]     ram_q, out_q;
   logic                 ram_vld_q, out_vld_q;
   logic                 out_adv, ram_adv, fetch;

   // Appending checks the open frame's pointer; a new frame always starts at wr_commit.
   assign full_app   = (wr_ptr_q - rd_ptr_q) == PtrDepth;
   assign full_start = (wr_commit_q - rd_ptr_q) == PtrDepth;
   assign free_beats = PtrDepth - (wr_ptr_q - rd_ptr_q);

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      wr_commit_d = wr_commit_q;
      frame_err_d = frame_err_q;
      error_d     = error_q;
      drop_a      = 1'b0;
      drop_b      = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = wr_ptr_q[LOG_DEPTH-1:0];
      start_frame = 1'b0;
      if (in_bus.valid) begin
         case (state_q)
            StRecv: begin
               if (in_bus.sop) begin
                  // Missing eop: the open frame is lost, this beat opens the next one.
                  drop_a      = 1'b1;
                  start_frame = 1'b1;
               end else if (full_app) begin
                  drop_a   = 1'b1;
                  wr_ptr_d = wr_commit_q;
                  state_d  = in_bus.eop ? StIdle : StDrop;
               end else begin
                  wr_en       = 1'b1;
                  wr_ptr_d    = wr_ptr_q + PtrOne;
                  frame_err_d = frame_err_q | in_bus.error;
                  if (in_bus.eop) begin
                     state_d = StIdle;
                     if (frame_err_q || in_bus.error) begin
                        drop_a   = 1'b1;
                        wr_ptr_d = wr_commit_q;
                     end else begin
                        wr_commit_d = wr_ptr_q + PtrOne;
                     end
                  end
               end
            end
            StDrop: begin
               if (in_bus.sop) begin
                  start_frame = 1'b1;
               end else if (in_bus.eop) begin
                  state_d = StIdle;
               end
            end
            default: begin
               if (in_bus.sop) begin
                  start_frame = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
            end
         endcase
         if (start_frame) begin
            wr_addr     = wr_commit_q[LOG_DEPTH-1:0];
            wr_ptr_d    = wr_commit_q;
            frame_err_d = in_bus.error;
            if (full_start) begin
               drop_b  = 1'b1;
               state_d = in_bus.eop ? StIdle : StDrop;
            end else if (in_bus.eop) begin
               state_d = StIdle;
               if (in_bus.error) begin
                  drop_b = 1'b1;
               end else begin
                  wr_en       = 1'b1;
                  wr_ptr_d    = wr_commit_q + PtrOne;
                  wr_commit_d = wr_commit_q + PtrOne;
               end
            end else begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_commit_q + PtrOne;
               state_d  = StRecv;
            end
         end
      end
   end

   // Two-stage show-ahead read: registered RAM read feeding the output register.
   assign out_adv = ~out_vld_q | out_bus.ready;
   assign ram_adv = ~ram_vld_q | out_adv;
   assign fetch   = (rd_ptr_q != wr_commit_q) & ram_adv;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= {in_bus.sop, in_bus.eop, in_bus.empty, in_bus.data};
      end
      if (fetch) begin
         ram_q <= mem[rd_ptr_q[LOG_DEPTH-1:0]];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         wr_commit_q <= '0;
         rd_ptr_q    <= '0;
         frame_err_q <= 1'b0;
         error_q     <= 1'b0;
         drop_cnt_q  <= '0;
         in_ready_q  <= 1'b0;
         ram_vld_q   <= 1'b0;
         out_vld_q   <= 1'b0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         wr_commit_q <= wr_commit_d;
         frame_err_q <= frame_err_d;
         error_q     <= error_d;
         drop_cnt_q  <= drop_cnt_q + 32'(drop_a) + 32'(drop_b);
         in_ready_q  <= free_beats >= PtrMax;
         if (fetch) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
         end
         ram_vld_q <= fetch | (ram_vld_q & ~out_adv);
         if (out_adv) begin
            out_vld_q <= ram_vld_q;
            if (ram_vld_q) begin
               out_q <= ram_q;
            end
         end
      end
   end

   assign in_bus.ready  = in_ready_q;
   assign out_bus.valid = out_vld_q;
   assign out_bus.error = 1'b0;
   assign {out_bus.sop, out_bus.eop, out_bus.empty, out_bus.data} = out_q;

   assign pckt_drop_cnt_out = drop_cnt_q;
   assign error             = error_q;
endmodule

// File: tb/tb_mac_tx_frame_buffer.sv
// Scoreboard bench for mac_tx_frame_buffer: kept frames are queued at drive time and compared
// beat by beat as the buffer emits them.
module tb_mac_tx_frame_buffer;
   typedef struct packed {
      logic         sop;
      logic         eop;
      logic [4:0]   empty;
      logic [255:0] data;
   } beat_t;

   logic        clk;
   logic        reset;
   logic [31:0] drop_cnt;
   logic        err_flag;
   int          n_vec;
   int          n_err;
   int          exp_drops;
   beat_t       sb[$];
   beat_t       exp_b;
   beat_t       held;
   logic        in_frame;
   logic        stall_prev;

   mac_tx_frame_buffer_if #(.DATA_WIDTH(256), .EMPTY_WIDTH(5)) in_if ();
   mac_tx_frame_buffer_if #(.DATA_WIDTH(256), .EMPTY_WIDTH(5)) out_if ();

   mac_tx_frame_buffer dut (
      .clk               (clk),
      .reset             (reset),
      .in_bus            (in_if),
      .out_bus           (out_if),
      .pckt_drop_cnt_out (drop_cnt),
      .error             (err_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_frame(input int n, input int err_beat, input bit keep, input bit with_eop,
                             input logic [4:0] last_empty);
      for (int b = 0; b < n; b++) begin
         beat_t bt;
         bt.sop   = (b == 0);
         bt.eop   = with_eop && (b == n - 1);
         bt.empty = bt.eop ? last_empty : 5'd0;
         for (int w = 0; w < 8; w++) bt.data[w*32 +: 32] = $urandom;
         in_if.valid = 1'b1;
         in_if.sop   = bt.sop;
         in_if.eop   = bt.eop;
         in_if.empty = bt.empty;
         in_if.data  = bt.data;
         in_if.error = (b == err_beat);
         if (keep) sb.push_back(bt);
         @(posedge clk);
         #1;
      end
      in_if.valid = 1'b0;
      in_if.sop   = 1'b0;
      in_if.eop   = 1'b0;
      in_if.error = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int c = 0;
      while (sb.size() != 0 && c < budget) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("drain", 256'(sb.size()), 256'(0));
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Output monitor: scoreboard compare, hold-while-stalled and no-gap checks.
   always @(negedge clk) begin
      if (reset) begin
         in_frame   = 1'b0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", 256'(out_if.valid), 256'(1));
            check("hold_data", out_if.data, held.data);
            check("hold_ctl", 256'({out_if.sop, out_if.eop, out_if.empty}),
                  256'({held.sop, held.eop, held.empty}));
         end
         if (in_frame && out_if.ready) check("no_gap", 256'(out_if.valid), 256'(1));
         if (out_if.valid && out_if.ready) begin
            check("sb_nonempty", 256'(sb.size() > 0), 256'(1));
            if (sb.size() > 0) begin
               exp_b = sb.pop_front();
               check("out_data", out_if.data, exp_b.data);
               check("out_ctl", 256'({out_if.sop, out_if.eop, out_if.empty}),
                     256'({exp_b.sop, exp_b.eop, exp_b.empty}));
               check("out_err", 256'(out_if.error), 256'(0));
            end
            if (out_if.sop) in_frame = !out_if.eop;
            else if (out_if.eop) in_frame = 1'b0;
         end
         stall_prev = out_if.valid && !out_if.ready;
         held       = {out_if.sop, out_if.eop, out_if.empty, out_if.data};
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
      $fatal(1);
   end

   initial begin
      n_vec        = 0;
      n_err        = 0;
      exp_drops    = 0;
      in_frame     = 1'b0;
      stall_prev   = 1'b0;
      in_if.valid  = 1'b0;
      in_if.sop    = 1'b0;
      in_if.eop    = 1'b0;
      in_if.empty  = '0;
      in_if.data   = '0;
      in_if.error  = 1'b0;
      out_if.ready = 1'b1;
      reset        = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 256'(out_if.valid), 256'(0));
      check("rst_in_ready", 256'(in_if.ready), 256'(0));
      check("rst_drop_cnt", 256'(drop_cnt), 256'(0));
      check("rst_error", 256'(err_flag), 256'(0));
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("in_ready_after_rst", 256'(in_if.ready), 256'(1));

      // Single 3-beat frame, latency from eop to sop output.
      send_frame(3, -1, 1'b1, 1'b1, 5'd12);
      check("lat_t0_valid", 256'(out_if.valid), 256'(0));
      @(posedge clk);
      #1;
      check("lat_t1_valid", 256'(out_if.valid), 256'(0));
      @(posedge clk);
      #1;
      check("lat_t2_valid", 256'(out_if.valid), 256'(1));
      check("lat_t2_sop", 256'(out_if.sop), 256'(1));
      wait_drain(50);
      check("drop_single", 256'(drop_cnt), 256'(exp_drops));

      // Ten back-to-back 2-beat frames while ready toggles.
      fork
         for (int f = 0; f < 10; f++) send_frame(2, -1, 1'b1, 1'b1, 5'(f));
         for (int blk = 0; blk < 4; blk++) begin
            int low = $urandom_range(2, 4);
            for (int c = 0; c < 10; c++) begin
               out_if.ready = (c >= low);
               @(posedge clk);
               #1;
            end
         end
      join
      out_if.ready = 1'b1;
      wait_drain(100);

      // Errored frame followed by a good one.
      send_frame(4, 1, 1'b0, 1'b1, 5'd3);
      exp_drops++;
      send_frame(3, -1, 1'b1, 1'b1, 5'd7);
      wait_drain(50);
      check("drop_errored", 256'(drop_cnt), 256'(exp_drops));

      // sop without eop, then a new frame.
      send_frame(2, -1, 1'b0, 1'b0, 5'd0);
      exp_drops++;
      send_frame(3, -1, 1'b1, 1'b1, 5'd1);
      wait_drain(50);
      check("drop_missing_eop", 256'(drop_cnt), 256'(exp_drops));

      // Overflow: ready low, ten 7-beat frames, the last does not fit.
      out_if.ready = 1'b0;
      for (int f = 0; f < 10; f++) send_frame(7, -1, (f < 9), 1'b1, 5'd2);
      exp_drops++;
      repeat (2) @(posedge clk);
      #1;
      check("drop_overflow", 256'(drop_cnt), 256'(exp_drops));
      check("in_ready_nearly_full", 256'(in_if.ready), 256'(0));
      check("overflow_sb_depth", 256'(sb.size()), 256'(63));
      out_if.ready = 1'b1;
      wait_drain(200);
      check("in_ready_drained", 256'(in_if.ready), 256'(1));

      // Stray beat outside a frame sets the sticky error.
      check("error_before", 256'(err_flag), 256'(0));
      in_if.valid = 1'b1;
      in_if.data  = 256'h1234;
      @(posedge clk);
      #1;
      in_if.valid = 1'b0;
      check("error_set", 256'(err_flag), 256'(1));
      @(posedge clk);
      #1;
      check("error_sticky", 256'(err_flag), 256'(1));
      check("drop_after_stray", 256'(drop_cnt), 256'(exp_drops));

      // Reset with one frame half-sent and another half-received.
      send_frame(8, -1, 1'b1, 1'b1, 5'd4);
      send_frame(3, -1, 1'b0, 1'b0, 5'd0);
      check("mid_tx_valid", 256'(out_if.valid), 256'(1));
      reset = 1'b1;
      #1;
      sb.delete();
      exp_drops = 0;
      check("mrst_valid", 256'(out_if.valid), 256'(0));
      check("mrst_ctl", 256'({out_if.sop, out_if.eop, out_if.empty}), 256'(0));
      check("mrst_data", out_if.data, 256'(0));
      check("mrst_in_ready", 256'(in_if.ready), 256'(0));
      check("mrst_drop_cnt", 256'(drop_cnt), 256'(0));
      check("mrst_error", 256'(err_flag), 256'(0));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      send_frame(4, -1, 1'b1, 1'b1, 5'd9);
      wait_drain(50);
      check("post_rst_drop_cnt", 256'(drop_cnt), 256'(0));
      check("post_rst_error", 256'(err_flag), 256'(0));
      check("final_sb_empty", 256'(sb.size()), 256'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mac_tx_frame_buffer.md
# mac_tx_frame_buffer

Store-and-forward frame buffer on the 256-bit Avalon-ST transmit path, placed directly downstream of the udp_ip TX output and upstream of the Ethernet MAC TX port. It accepts whole frames, releases a frame to the MAC only once its eop beat is stored, and streams that frame without bubbles while the MAC holds ready. Partial, errored or overflowing frames are discarded and counted. This keeps MAC underflow and mid-frame ready stalls away from udp_ip.

## Interface
- DATA_WIDTH, 256, beat data width
- EMPTY_WIDTH, 5, log2(DATA_WIDTH/8)
- LOG_DEPTH, 6, log2 of buffer depth in beats (64)
- MAX_FRAME_BEATS, 8, space needed before in_ready_out asserts

- clk  in  1  single clock for both ports
- reset  in  1  asynchronous, active-high
- in_data_in  in  DATA_WIDTH  sink beat data
- in_valid_in  in  1  sink beat valid
- in_sop_in / in_eop_in  in  1 each  start/end of frame
- in_empty_in  in  EMPTY_WIDTH  unused bytes in eop beat
- in_error_in  in  1  frame error, sampled on any beat of the frame
- in_ready_out  out  1  free beats >= MAX_FRAME_BEATS
- out_data_out  out  DATA_WIDTH  source beat data
- out_valid_out, out_sop_out, out_eop_out  out  1 each
- out_empty_out  out  EMPTY_WIDTH
- out_error_out  out  1  tied 0 (errored frames never leave)
- out_ready_in  in  1  MAC ready
- pckt_drop_cnt_out  out  32  wrapping count of dropped frames
- error  out  1  sticky: beat with in_valid_in while no frame open and no sop

## Operation
- Beat storage: RAM of 2^LOG_DEPTH entries of {data, sop, eop, empty}. Pointers are LOG_DEPTH+1 bits, wrap naturally; full when wr_ptr - rd_ptr == 2^LOG_DEPTH.
- Pointers: wr_ptr (speculative), wr_commit (end of last good frame), rd_ptr.
- Write FSM, states IDLE, RECV, DROP:
  - IDLE: valid&sop -> write beat, go RECV (or commit directly if eop too). valid without sop -> discard beat, set error.
  - RECV: valid beat appended; frame_err |= in_error_in. On eop: if !frame_err, wr_commit <= wr_ptr+1, else wr_ptr <= wr_commit, drop_cnt++; -> IDLE.
  - RECV, valid&sop (missing eop): rewind wr_ptr to wr_commit, drop_cnt++, new beat starts a new frame; stay RECV.
  - RECV, valid while full: rewind wr_ptr to wr_commit, drop_cnt++, go DROP (or IDLE if beat is eop).
  - DROP: discard beats; eop -> IDLE; sop -> start new frame in RECV (no extra drop count).
- Frames longer than 2^LOG_DEPTH beats are always dropped.
- Read side: out_valid_out high whenever rd_ptr != wr_commit (committed beats exist). Show-ahead output register; beat advances on out_valid_out & out_ready_in. While valid & !ready, all out_* hold stable.
- Simultaneous commit of frame k and read of frame k-1: both take effect, no loss.
- in_ready_out is advisory; the buffer never stalls input, it drops.

## Timing
- Reset (async assert, sync release): all pointers 0, FSM IDLE, out_valid_out 0, out_sop/eop/empty/data 0, in_ready_out 0 during reset and 1 from first edge after release, pckt_drop_cnt_out 0, error 0.
- Reset mid-frame: buffer contents and any in-flight output frame discarded; no drop count.
- Latency: eop beat sampled at edge t -> wr_commit updated at t -> out_valid_out with that frame's sop beat after edge t+2 (if buffer was empty).
- Throughput: 1 beat/cycle in and out; a committed frame streams contiguously while out_ready_in=1.
- pckt_drop_cnt_out updates the edge after the dropping event; wraps 0xFFFFFFFF -> 0.
- in_ready_out registered; reflects free space one cycle late.

## Test plan
- Single 3-beat frame (empty=12 on eop), out_ready_in=1 -> identical 3 beats on out after 2 cycles from eop, sop on beat 0, eop/empty=12 on beat 2, drop count 0.
- 10 back-to-back 2-beat frames with out_ready_in toggled pseudo-randomly (low 2-4 of every 10 cycles) -> all 20 beats delivered in order, data stable while stalled, no gaps inside a frame when ready high.
- Frame with in_error_in on beat 1 of 4 followed by a good frame -> only the good frame emitted, pckt_drop_cnt_out = 1.
- sop, beat, then sop again without eop, then eop -> first partial frame dropped (count 1), second frame delivered intact.
- out_ready_in=0, push 70 beats as ten 7-beat frames -> first 9 frames kept (63 beats), frame 10 dropped on overflow (count 1); release ready -> 63 beats out.
- Assert reset while a frame is half-received and another half-sent -> all outputs return to reset values; next frame after release passes unchanged, count 0.
